// File: rtl/reg_writer.sv
// Writeback consumer: commits per-instruction beats into a 16-entry register file,
// holding loads in WAIT until the memory response (or timeout), with bypassed read ports.
module reg_writer #(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 255,
  parameter int TO_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      wb_rd,
  input  logic [3:0]      wb_mask,
  input  logic            wb_mre,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            n_stall,
  input  logic [3:0]      rs1,
  input  logic [3:0]      rs2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            load_err,
  output logic [31:0]     commit_cnt
);

  localparam int NB = XLEN / 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOAD_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic [TO_W-1:0] wait_cnt;
  logic [3:0]      lat_rd;
  logic [NB-1:0]   lat_mask;
  logic [XLEN-1:0] regs [16];

  logic            wr_vld;
  logic            wr_en;
  logic [3:0]      wr_rd;
  logic [NB-1:0]   wr_mask;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] wr_new;

  function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] new_val,
                                                  input logic [NB-1:0]   mask);
    logic [XLEN-1:0] r;
    r = old_val;
    for (int i = 0; i < NB; i++)
      if (mask[i]) r[8*i +: 8] = new_val[8*i +: 8];
    return r;
  endfunction

  // Select the beat that commits at the coming edge, if any.
  always_comb begin
    wr_vld  = 1'b0;
    wr_rd   = wb_rd;
    wr_mask = wb_mask;
    wr_data = alu_result;
    if (state == IDLE) begin
      if (!wb_mre) begin
        wr_vld = 1'b1;
      end else if (mem_rvalid) begin
        wr_vld  = 1'b1;
        wr_data = mem_rdata;
      end
    end else if (mem_rvalid) begin
      wr_vld  = 1'b1;
      wr_rd   = lat_rd;
      wr_mask = lat_mask;
      wr_data = mem_rdata;
    end
  end

  assign wr_en   = wr_vld && (wr_rd != 4'd0);
  assign wr_new  = merge_lanes(regs[wr_rd], wr_data, wr_mask);
  assign n_stall = (state == IDLE) && !(wb_mre && !mem_rvalid);

  // Read ports see the merged value of a write landing at the coming edge.
  assign rdata1 = (rs1 == 4'd0) ? '0 : (wr_en && wr_rd == rs1) ? wr_new : regs[rs1];
  assign rdata2 = (rs2 == 4'd0) ? '0 : (wr_en && wr_rd == rs2) ? wr_new : regs[rs2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_rd     <= '0;
      lat_mask   <= '0;
      load_err   <= 1'b0;
      commit_cnt <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      if (wr_en) begin
        regs[wr_rd] <= wr_new;
        commit_cnt  <= commit_cnt + 32'd1;
      end
      case (state)
        IDLE: begin
          if (wb_mre && !mem_rvalid) begin
            lat_rd   <= wb_rd;
            lat_mask <= wb_mask;
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end else if (wait_cnt == TO_LAST) begin
            load_err <= 1'b1;
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TO_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_writer.sv
// Directed bench for reg_writer: stimulus pushes per-cycle expectations into a
// scoreboard queue; a negedge monitor pops and compares against the DUT outputs.
module tb_reg_writer;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      wb_rd = '0;
  logic [3:0]      wb_mask = '0;
  logic            wb_mre = 1'b0;
  logic [XLEN-1:0] alu_result = '0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            mem_rvalid = 1'b0;
  logic            n_stall;
  logic [3:0]      rs1 = '0;
  logic [3:0]      rs2 = '0;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            load_err;
  logic [31:0]     commit_cnt;

  reg_writer #(.XLEN(XLEN), .LOAD_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .wb_rd(wb_rd), .wb_mask(wb_mask), .wb_mre(wb_mre),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .n_stall(n_stall), .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
    .load_err(load_err), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sel;   // 0 rdata1, 1 rdata2, 2 n_stall, 3 load_err, 4 commit_cnt
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  logic [31:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = rdata1;
        1:       act = rdata2;
        2:       act = {31'd0, n_stall};
        3:       act = {31'd0, load_err};
        default: act = commit_cnt;
      endcase
      n_run++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_now(input int sel, input logic [31:0] v, input string nm);
    exp_t x;
    x.cyc = cyc; x.sel = sel; x.val = v; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wb_rd = '0; wb_mask = '0; wb_mre = 1'b0; alu_result = '0;
    mem_rdata = '0; mem_rvalid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    rs1 = 4'd5;
    expect_now(0, 32'h0, "rst_rdata1");
    expect_now(2, 32'h1, "rst_n_stall");
    expect_now(3, 32'h0, "rst_load_err");
    expect_now(4, 32'h0, "rst_commit_cnt");

    // Full write with same-cycle bypass
    step();
    wb_rd = 4'd3; wb_mask = 4'hF; alu_result = 32'hDEADBEEF; rs1 = 4'd3;
    expect_now(0, 32'hDEADBEEF, "bypass_full");
    expect_now(4, 32'h0, "cnt_before_commit");
    step();
    rs1 = 4'd3;
    expect_now(0, 32'hDEADBEEF, "r3_full");
    expect_now(4, 32'h1, "cnt_after_first");

    // Single-lane masked write, bypass on port 2
    step();
    wb_rd = 4'd3; wb_mask = 4'b0010; alu_result = 32'h0000AA00; rs2 = 4'd3;
    expect_now(1, 32'hDEADAAEF, "bypass_masked");
    step();
    expect_now(0, 32'hDEADAAEF, "r3_masked");
    expect_now(4, 32'h2, "cnt_after_masked");

    // Write to r0 is discarded
    step();
    wb_rd = 4'd0; wb_mask = 4'hF; alu_result = 32'h12345678; rs1 = 4'd0;
    expect_now(0, 32'h0, "r0_bypass_none");
    step();
    expect_now(0, 32'h0, "r0_reads_zero");
    expect_now(4, 32'h2, "cnt_r0_no_commit");

    // mask=0 still commits, value unchanged
    step();
    wb_rd = 4'd4; wb_mask = 4'h0; alu_result = 32'hFFFFFFFF; rs1 = 4'd4;
    expect_now(0, 32'h0, "mask0_bypass");
    step();
    expect_now(0, 32'h0, "mask0_r4");
    expect_now(4, 32'h3, "cnt_mask0");

    // Stray rvalid with a non-load beat: alu data wins
    step();
    wb_rd = 4'd5; wb_mask = 4'hF; alu_result = 32'h11111111;
    mem_rdata = 32'h99999999; mem_rvalid = 1'b1; rs1 = 4'd5;
    expect_now(0, 32'h11111111, "stray_bypass");
    expect_now(2, 32'h1, "stray_no_stall");
    step();
    expect_now(0, 32'h11111111, "stray_r5");
    expect_now(3, 32'h0, "stray_no_err");
    expect_now(4, 32'h4, "cnt_stray");

    // Load with 3-cycle response latency
    step();
    wb_rd = 4'd7; wb_mask = 4'hF; wb_mre = 1'b1; rs1 = 4'd7;
    expect_now(2, 32'h0, "load_entry_stall");
    for (int i = 0; i < 2; i++) begin
      step();
      wb_rd = 4'd7; wb_mask = 4'hF; alu_result = 32'hBADBAD00;
      expect_now(2, 32'h0, "load_wait_stall");
      expect_now(0, 32'h0, "load_wait_ignored");
    end
    step();
    mem_rdata = 32'hCAFEF00D; mem_rvalid = 1'b1;
    expect_now(2, 32'h0, "load_rvalid_stall");
    expect_now(0, 32'hCAFEF00D, "load_bypass");
    step();
    expect_now(2, 32'h1, "load_done_unstall");
    expect_now(0, 32'hCAFEF00D, "load_r7");
    expect_now(4, 32'h5, "cnt_load");

    // Load with immediate response
    step();
    wb_rd = 4'd7; wb_mask = 4'hF; wb_mre = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h00000055;
    expect_now(2, 32'h1, "fast_load_no_stall");
    step();
    expect_now(0, 32'h00000055, "fast_load_r7");
    expect_now(4, 32'h6, "cnt_fast_load");

    // Timeout: LOAD_TIMEOUT=4 -> 4 WAIT cycles, then error, no write
    step();
    wb_rd = 4'd9; wb_mask = 4'hF; wb_mre = 1'b1; rs1 = 4'd9;
    expect_now(2, 32'h0, "to_entry_stall");
    for (int i = 0; i < 4; i++) begin
      step();
      expect_now(2, 32'h0, "to_wait_stall");
      expect_now(3, 32'h0, "to_err_pending");
    end
    step();
    expect_now(2, 32'h1, "to_unstall");
    expect_now(3, 32'h1, "to_load_err");
    expect_now(0, 32'h0, "to_r9_unchanged");
    expect_now(4, 32'h6, "to_cnt_unchanged");

    // Reset mid-WAIT aborts the load; later rvalid is ignored
    step();
    wb_rd = 4'd10; wb_mask = 4'hF; wb_mre = 1'b1; rs1 = 4'd10;
    expect_now(2, 32'h0, "rw_entry_stall");
    step();
    expect_now(2, 32'h0, "rw_wait_stall");
    step();
    rst = 1'b1;
    #1;
    expect_now(2, 32'h1, "rw_rst_unstall");
    expect_now(3, 32'h0, "rw_rst_err_clear");
    expect_now(4, 32'h0, "rw_rst_cnt_clear");
    step();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    expect_now(2, 32'h1, "rw_late_rvalid_nstall");
    step();
    expect_now(0, 32'h0, "rw_r10_no_write");
    rs2 = 4'd7;
    expect_now(1, 32'h0, "rw_r7_cleared");
    expect_now(4, 32'h0, "rw_cnt_zero");

    repeat (3) step();
    n_run++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
